// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one iterative 32-bit divider among NUM_REQ requesters.
// It issues the start pulse, waits out the divider latency with an abort budget, and returns the result to the owner.
module div_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_signed,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_q,
    output logic [31:0]            resp_r,
    output logic                   resp_timeout,
    output logic                   busy,
    output logic                   div_start,
    output logic                   div_signed,
    output logic [31:0]            div_a,
    output logic [31:0]            div_b,
    output logic                   div_flush,
    input  logic                   div_rdy,
    input  logic [31:0]            div_q,
    input  logic [31:0]            div_r
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   grant;
    logic            grant_vld;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            sel_s;
    logic [31:0]     tcnt;
    logic            tmo_hit;

    // Two passes give the first set bit at or above rr, then wrap to the bottom.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_valid[i] && (i >= 32'(rr))) begin
                grant_vld = 1'b1;
                grant     = PW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_valid[i]) begin
                grant_vld = 1'b1;
                grant     = PW'(i);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == grant) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
                sel_s = req_signed[i];
            end
        end
    end

    assign tmo_hit = (TIMEOUT != 0) && (tcnt == 32'(TIMEOUT - 1));

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        div_start  = 1'b0;
        div_flush  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by reset so the accept pulse is also silent while reset is held.
                if (grant_vld && reset) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = ISSUE;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                state_nxt = ARM;
            end
            ARM: state_nxt = WAIT;
            WAIT: begin
                if (div_rdy) begin
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    div_flush = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid[owner] = 1'b1;
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr           <= '0;
            owner        <= '0;
            div_a        <= '0;
            div_b        <= '0;
            div_signed   <= 1'b0;
            tcnt         <= '0;
            resp_q       <= '0;
            resp_r       <= '0;
            resp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        div_a      <= sel_a;
                        div_b      <= sel_b;
                        div_signed <= sel_s;
                        owner      <= grant;
                        rr         <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                ARM: tcnt <= '0;
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (div_rdy) begin
                        resp_q       <= div_q;
                        resp_r       <= div_r;
                        resp_timeout <= 1'b0;
                    end else if (tmo_hit) begin
                        resp_q       <= '1;
                        resp_r       <= '0;
                        resp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
